wor_bus_arbiter: RTL
====================

# wor_bus_arbiter

Round-robin arbiter and sequencer for a shared wired-OR data line with N requesters. Only the granted requester's data reaches the line; all others drive zero, so the OR-resolved value is always the owner's word. A one-cycle turnaround separates consecutive owners. The block sits between the requesting units and the shared wor net and replaces free-for-all driving of that net.

## Interface
- N, default 4: number of requesters, legal range 2..8.
- W, default 8: data width of the shared line.
- MAX_HOLD, default 8: maximum consecutive OWN cycles per tenure when the timeout is compiled in, legal range 1..255.
- IW, derived, $clog2(N): owner index width. Not user-set.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request from requester i on bit i.
- din  input  N*W  requester i data on bits [i*W +: W].
- gnt  output  N  registered grant; one-hot or all-zero.
- busy  output  1  high when state is not IDLE.
- owner  output  IW  index of the granted requester; 0 when gnt is zero.
- bus_out  output  W  wired-OR resolution: OR over i of (gnt[i] ? din_i : 0).

## Operation
- State machine with states IDLE, OWN and TURN.
- IDLE:
  - If any req bit is high, select the first set bit scanning ptr, ptr+1, …, wrapping mod N.
  - Load gnt with the one-hot for index k and go to OWN.
  - If no req bit is high, stay in IDLE with gnt = 0.
- OWN:
  - gnt[k] is held.
  - If req[k] is low, go to TURN and clear gnt.
  - Other requesters' req bits are ignored while in OWN.
- TURN:
  - Lasts exactly one cycle with gnt = 0 and bus_out = 0.
  - ptr is updated to (k+1) mod N.
  - Next state is IDLE.
- ptr is a round-robin pointer of width IW, updated only on the OWN→TURN transition.
- hold_cnt is an 8-bit counter:
  - Cleared on entering OWN.
  - Incremented in each OWN cycle.
  - Saturates at 255.
- bus_out is combinational from registered gnt and live din; there is no data register.
- If a requester deasserts req while in IDLE before being granted, it is simply not selected; no error is raised.

## Timing
- Reset values: state IDLE, gnt 0, owner 0, busy 0, bus_out 0, ptr 0, hold_cnt 0.
- Reset takes effect at the first rising edge with rst high and applies in any state. A reset mid-tenure drops gnt immediately at that edge, with no TURN cycle.
- Grant latency: req sampled in an IDLE cycle produces gnt high after the next edge, i.e. 1 cycle.
- Release: req[k] low in an OWN cycle produces gnt low after the next edge. This is followed by 1 TURN cycle and 1 IDLE cycle. The next grant is visible at the earliest 3 edges after req[k] falls.
- Simultaneous requests are resolved by the ptr order only. Wrap-around: after owner N-1, ptr is 0.
- bus_out follows din[k] in the same cycle while gnt[k] is high.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In OWN, when hold_cnt == MAX_HOLD-1 and req[k] is still high, go to TURN.
  - This is a forced release: gnt is held for exactly MAX_HOLD cycles.
  - ptr advances as for a normal release, so k re-competes behind the others.
- Not defined:
  - hold_cnt is still present, but no forced release occurs.
  - A requester owns the line for as long as its req stays high.

## Test plan
- Single requester: N=4, W=8, req=0010 from cycle 2, din_1=8'hA5.
  - gnt=0010 and owner=1 from cycle 3.
  - bus_out=8'hA5 while granted; all other din are ignored.
- Simultaneous requests after reset: req=1111, each requester drops req after 2 OWN cycles.
  - Grant order is 0,1,2,3,0.
  - Exactly one TURN cycle (gnt=0, bus_out=0) between tenures.
- Wrap-around and fairness: after owner 3 releases, req=1001.
  - Requester 0 is granted next, then 3.
- Timeout with ARB_TIMEOUT_EN defined, MAX_HOLD=4: req=0001 held high, req=0100 also high.
  - gnt=0001 for exactly 4 cycles, then TURN, IDLE, then gnt=0100.
- Timeout without ARB_TIMEOUT_EN, same stimulus:
  - gnt=0001 stays high for 20 cycles until req[0] falls.
- Reset mid-tenure: rst high for 1 cycle during OWN with owner=2.
  - gnt=0, owner=0, busy=0, bus_out=0 at the next edge.
  - With req=0101 afterwards, the next grant goes to requester 0 because ptr was reset.

Source files
------------

// File: rtl/wor_bus_arbiter.sv
// Round-robin owner sequencer for a shared wired-OR data line, with a one-cycle turnaround between owners.
// Optional forced release after MAX_HOLD cycles is compiled in with `define ARB_TIMEOUT_EN.
module wor_bus_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 8,
  localparam int IW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic [IW-1:0]  owner,
  output logic [W-1:0]   bus_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_TURN
  } state_e;

`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e          state_q;
  logic [N-1:0]    gnt_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   ptr_q;
  logic [7:0]      hold_cnt_q;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   ptr_d;
  logic [7:0]      hold_cnt_d;
  logic            timeout_hit;
  logic            release_own;

  // Scan from the farthest offset down so the candidate nearest to ptr is written last and wins.
  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = int'(ptr_q) + off;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(idx);
      end
    end
  end

  assign ptr_d       = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
  assign hold_cnt_d  = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
  assign timeout_hit = TIMEOUT_EN && req[owner_q] && (hold_cnt_q == HOLD_LAST);
  assign release_own = !req[owner_q] || timeout_hit;

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q    <= ST_OWN;
            gnt_q      <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            owner_q    <= pick_idx;
            hold_cnt_q <= '0;
          end
        end
        ST_OWN: begin
          hold_cnt_q <= hold_cnt_d;
          if (release_own) begin
            state_q <= ST_TURN;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= ptr_d;
          end
        end
        ST_TURN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          owner_q <= '0;
        end
      endcase
    end
  end

  // Non-owners contribute zero, so the OR reduces to the owner's live word.
  always_comb begin
    bus_out = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) bus_out = bus_out | din[i*W +: W];
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = (state_q != ST_IDLE);

  a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(gnt_q));

endmodule
